// File: rtl/dff_debounce_edge_if.sv
// Purpose: level/strobe bundle between a debouncer and its surroundings.
//   i_d     raw input level (driven by the pin side)
//   o_q     debounced level
//   o_rise  one-cycle strobe on accepted 0->1
//   o_fall  one-cycle strobe on accepted 1->0
//   o_busy  high while a candidate change is being counted
interface dff_debounce_edge_if;
  logic i_d;
  logic o_q;
  logic o_rise;
  logic o_fall;
  logic o_busy;

  // Pin/consumer side: drives the raw level, observes the conditioned outputs.
  modport master (
    output i_d,
    input  o_q,
    input  o_rise,
    input  o_fall,
    input  o_busy
  );

  // Debouncer side.
  modport slave (
    input  i_d,
    output o_q,
    output o_rise,
    output o_fall,
    output o_busy
  );
endinterface

// File: rtl/dff_debounce_edge.sv
// Purpose: input conditioning for a raw/asynchronous 1-bit level. The level is
//   synchronised through a SYNC_STAGES flop chain, then accepted as the new
//   debounced level only after DEBOUNCE_CYCLES consecutive cycles of
//   disagreeing with the current one. Each accept raises exactly one of
//   o_rise/o_fall for one cycle.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      dff_debounce_edge_if.slave (i_d in; o_q, o_rise, o_fall, o_busy out)
module dff_debounce_edge #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  dff_debounce_edge_if.slave bus
);

  localparam int unsigned      CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // A single disagreeing cycle is already enough: skip the counting state.
  localparam bit               ACCEPT_NOW = (DEBOUNCE_CYCLES == 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: synchroniser shift plus stability counter FSM.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_d};
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      ST_STABLE: begin
        if (s != q_q) begin
          if (ACCEPT_NOW) begin
            q_d    = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (s == q_q) begin
          // Candidate fell back before qualifying: drop it silently.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          q_d     = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase

    // Registered so busy reflects the state the FSM has just entered.
    busy_d = (state_d == ST_COUNT);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_q    = q_q;
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;
  assign bus.o_busy = busy_q;

endmodule
